// File: rtl/xaui_link_pkg.sv
// ---------------------------------------------------------------------------
// xaui_link_pkg
// Shared definitions for the XAUI link bring-up sequencer:
//   - link_state_e : 3-bit FSM state encoding (IDLE..BACKOFF = 0..7), also
//                    presented on the xaui_link_ctrl "state" output.
//   - bit positions inside the 8-bit XAUI core status vector.
//   - max_int      : elaboration-time helper for sizing counters.
// ---------------------------------------------------------------------------
package xaui_link_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RST_TX     = 3'd1,
        RST_RX     = 3'd2,
        WAIT_SYNC  = 3'd3,
        WAIT_ALIGN = 3'd4,
        QUALIFY    = 3'd5,
        UP         = 3'd6,
        BACKOFF    = 3'd7
    } link_state_e;

    // xaui_status bit positions
    localparam int TX_FAULT = 0;
    localparam int RX_FAULT = 1;
    localparam int SYNC_LO  = 2;   // lane sync occupies [SYNC_LO +: 4]
    localparam int ALIGN    = 6;
    localparam int RX_LINK  = 7;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/xaui_link_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at SAT_MAX instead of wrapping. clear has priority
// over a simultaneous inc.
// Ports:
//   clk      in   clock
//   reset_n  in   asynchronous active-low reset (count -> 0)
//   clear    in   synchronous clear
//   inc      in   increment request
//   count    out  WIDTH-bit registered count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] SAT_MAX = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != SAT_MAX)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/xaui_link_ctrl.sv
// ---------------------------------------------------------------------------
// xaui_link_ctrl
// Link bring-up and recovery sequencer for one 4-lane XAUI PHY. Drives the
// MGT TX/RX resets, waits for CDR lock, lane sync and alignment, qualifies
// the link over QUAL_CYCLES consecutive good-status cycles, and retries with
// exponential backoff when the bring-up window times out.
//
// Optional build macro: XAUI_LINK_CTRL_STATS_EN adds stats_clear,
// drop_count and timeout_count (16-bit saturating).
//
// Ports:
//   clk               in   user clock shared with the XAUI core
//   reset_n           in   asynchronous active-low reset
//   enable            in   0 forces IDLE (all resets asserted)
//   force_retrain     in   pulse: restart at RST_TX (ignored in IDLE)
//   xaui_status[7:0]  in   core status (faults, lane sync, align, rx link)
//   mgt_rxlock[3:0]   in   per-lane CDR lock
//   mgt_tx_reset[3:0] out  per-lane TX reset
//   mgt_rx_reset[3:0] out  per-lane RX reset
//   cfg_status_reset  out  core reset-link/reset-fault config bits
//   link_up           out  qualified link good
//   state[2:0]        out  current FSM state
//   retry_count[7:0]  out  timeouts since last link-up (saturating)
//   link_drop         out  one-cycle pulse when leaving UP
//   stats_clear       in   (STATS_EN) zero both stats counters
//   drop_count[15:0]  out  (STATS_EN) number of UP exits
//   timeout_count[15:0] out (STATS_EN) number of bring-up timeouts
// ---------------------------------------------------------------------------
module xaui_link_ctrl
    import xaui_link_pkg::*;
#(
    parameter int RST_CYCLES   = 16,
    parameter int TIMEOUT_BITS = 20,
    parameter int QUAL_CYCLES  = 1024,
    parameter int BACKOFF_MAX  = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       force_retrain,
    input  logic [7:0] xaui_status,
    input  logic [3:0] mgt_rxlock,
    output logic [3:0] mgt_tx_reset,
    output logic [3:0] mgt_rx_reset,
    output logic       cfg_status_reset,
    output logic       link_up,
    output logic [2:0] state,
    output logic [7:0] retry_count,
    output logic       link_drop
`ifdef XAUI_LINK_CTRL_STATS_EN
    ,
    input  logic        stats_clear,
    output logic [15:0] drop_count,
    output logic [15:0] timeout_count
`endif
);

    // One phase counter is shared by RST_TX, RST_RX hold, QUALIFY and
    // BACKOFF, so it is sized for the largest of them (the longest backoff).
    localparam int BO_BASE = TIMEOUT_BITS - 8;
    localparam int CNT_W   = max_int(max_int($clog2(QUAL_CYCLES + 1), $clog2(RST_CYCLES + 1)),
                                     BO_BASE + BACKOFF_MAX + 1);
    localparam int EXP_W   = max_int(1, $clog2(BACKOFF_MAX + 1));

    localparam logic [CNT_W-1:0]        RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]        RST_HOLD  = CNT_W'(RST_CYCLES);
    localparam logic [CNT_W-1:0]        QUAL_LAST = CNT_W'(QUAL_CYCLES - 1);
    localparam logic [EXP_W-1:0]        EXP_MAX   = EXP_W'(BACKOFF_MAX);
    // The timeout counter starts at 0 on RST_RX entry, so the window of
    // 2^TIMEOUT_BITS-1 cycles ends when it reads all-ones minus one.
    localparam logic [TIMEOUT_BITS-1:0] TO_LAST   = {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};

    link_state_e             state_q, state_nxt;
    logic [CNT_W-1:0]        cnt_q, cnt_nxt;
    logic [TIMEOUT_BITS-1:0] to_cnt_q, to_cnt_nxt;
    logic [EXP_W-1:0]        bo_exp_q, bo_exp_nxt;
    logic [CNT_W-1:0]        bo_last;

    logic good_status;
    logic timed_cur;
    logic timed_nxt;
    logic to_expired;
    logic to_taken;
    logic bo_done;
    logic leave_up;
    logic retrain_req;
    logic unused_rx_link;

    logic [3:0] tx_reset_nxt, rx_reset_nxt;
    logic       cfg_reset_nxt, link_up_nxt, link_drop_nxt;

    assign unused_rx_link = xaui_status[RX_LINK];

    assign good_status = (xaui_status[SYNC_LO +: 5] == 5'h1F) &&
                         !xaui_status[TX_FAULT] && !xaui_status[RX_FAULT];

    assign timed_cur  = state_q inside {RST_RX, WAIT_SYNC, WAIT_ALIGN, QUALIFY};
    assign to_expired = timed_cur && (to_cnt_q == TO_LAST);
    assign bo_last    = (CNT_W'(1) << (BO_BASE + int'(bo_exp_q))) - CNT_W'(1);
    assign retrain_req = enable && force_retrain && (state_q != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            to_cnt_q         <= '0;
            bo_exp_q         <= '0;
            mgt_tx_reset     <= 4'hF;
            mgt_rx_reset     <= 4'hF;
            cfg_status_reset <= 1'b1;
            link_up          <= 1'b0;
            link_drop        <= 1'b0;
        end else begin
            state_q          <= state_nxt;
            cnt_q            <= cnt_nxt;
            to_cnt_q         <= to_cnt_nxt;
            bo_exp_q         <= bo_exp_nxt;
            mgt_tx_reset     <= tx_reset_nxt;
            mgt_rx_reset     <= rx_reset_nxt;
            cfg_status_reset <= cfg_reset_nxt;
            link_up          <= link_up_nxt;
            link_drop        <= link_drop_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        to_taken  = 1'b0;
        bo_done   = 1'b0;

        if (!enable) begin
            state_nxt = IDLE;
        end else if (force_retrain && (state_q != IDLE)) begin
            state_nxt = RST_TX;
        end else if (to_expired) begin
            state_nxt = BACKOFF;
            to_taken  = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: state_nxt = RST_TX;
                RST_TX: begin
                    if (cnt_q == RST_LAST) state_nxt = RST_RX;
                    else                   cnt_nxt   = cnt_q + CNT_W'(1);
                end
                RST_RX: begin
                    // Hold period only accumulates while all lanes stay locked.
                    if (mgt_rxlock != 4'hF)     cnt_nxt   = '0;
                    else if (cnt_q == RST_HOLD) state_nxt = WAIT_SYNC;
                    else                        cnt_nxt   = cnt_q + CNT_W'(1);
                end
                WAIT_SYNC: begin
                    if (xaui_status[SYNC_LO +: 4] == 4'hF) state_nxt = WAIT_ALIGN;
                end
                WAIT_ALIGN: begin
                    if (xaui_status[ALIGN]) state_nxt = QUALIFY;
                end
                QUALIFY: begin
                    if (!good_status)            cnt_nxt   = '0;
                    else if (cnt_q == QUAL_LAST) state_nxt = UP;
                    else                         cnt_nxt   = cnt_q + CNT_W'(1);
                end
                UP: begin
                    if (!good_status) state_nxt = RST_TX;
                end
                BACKOFF: begin
                    if (cnt_q == bo_last) begin
                        state_nxt = RST_TX;
                        bo_done   = 1'b1;
                    end else begin
                        cnt_nxt = cnt_q + CNT_W'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        // Every phase starts counting from zero; a retrain inside RST_TX
        // does not change state but must still restart the pulse.
        if ((state_nxt != state_q) || retrain_req) begin
            cnt_nxt = '0;
        end
    end

    // Timeout window spans RST_RX..QUALIFY without restarting between them.
    assign timed_nxt  = state_nxt inside {RST_RX, WAIT_SYNC, WAIT_ALIGN, QUALIFY};
    assign to_cnt_nxt = (timed_cur && timed_nxt) ? to_cnt_q + TIMEOUT_BITS'(1) : '0;

    always_comb begin
        bo_exp_nxt = bo_exp_q;
        if (state_nxt == UP) begin
            bo_exp_nxt = '0;
        end else if (bo_done && (bo_exp_q != EXP_MAX)) begin
            bo_exp_nxt = bo_exp_q + EXP_W'(1);
        end
    end

    // Outputs are registered from the next state so they line up with state.
    assign leave_up = (state_q == UP) && (state_nxt != UP);

    always_comb begin
        tx_reset_nxt  = {4{state_nxt inside {IDLE, RST_TX, BACKOFF}}};
        rx_reset_nxt  = {4{state_nxt inside {IDLE, RST_TX, RST_RX, BACKOFF}}};
        cfg_reset_nxt = (state_nxt inside {IDLE, RST_TX, BACKOFF}) ||
                        ((state_nxt == QUALIFY) && (state_q != QUALIFY));
        link_up_nxt   = (state_nxt == UP);
        link_drop_nxt = leave_up;
    end

    assign state = state_q;

    sat_counter #(.WIDTH(8)) u_retry_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state_nxt == UP),
        .inc     (to_taken),
        .count   (retry_count)
    );

`ifdef XAUI_LINK_CTRL_STATS_EN
    sat_counter #(.WIDTH(16)) u_drop_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (stats_clear),
        .inc     (leave_up),
        .count   (drop_count)
    );

    sat_counter #(.WIDTH(16)) u_timeout_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (stats_clear),
        .inc     (to_taken),
        .count   (timeout_count)
    );
`endif

endmodule

// File: doc/xaui_link_ctrl.md
Name: xaui_link_ctrl

Overview:
- Link bring-up and recovery sequencer for one 4-lane XAUI PHY instance.
- Sits between the XAUI core status/configuration interface and the MGT reset inputs, and replaces the free-running rx-reset stretcher.
- Sequences TX/RX MGT resets, waits for lane sync and alignment, then qualifies link-up.
- On failure, retries with exponential backoff and reports link state to the register interface.

Parameters:
- RST_CYCLES, 16: MGT reset pulse width in clk cycles (≥2).
- TIMEOUT_BITS, 20: width of the sync/align timeout counter; timeout = 2^TIMEOUT_BITS−1 cycles.
- QUAL_CYCLES, 1024: consecutive cycles of good status required before declaring link up.
- BACKOFF_MAX, 4: maximum backoff exponent; backoff wait = 2^(TIMEOUT_BITS−8+exp) cycles.

Ports:
- clk  in  1  user clock shared with the XAUI core.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  0 holds the MGTs in reset (state IDLE).
- force_retrain  in  1  single-cycle pulse requesting a full reset sequence.
- xaui_status  in  8  core status: [0] tx fault, [1] rx fault, [5:2] lane sync, [6] align, [7] rx link.
- mgt_rxlock  in  4  per-lane CDR lock.
- mgt_tx_reset  out  4  per-lane TX reset (all lanes equal).
- mgt_rx_reset  out  4  per-lane RX reset (all lanes equal).
- cfg_status_reset  out  1  drives the core configuration vector reset-link/reset-fault bits.
- link_up  out  1  qualified link good.
- state  out  3  current FSM state encoding.
- retry_count  out  8  failed attempts since last link-up; saturates at 255.
- link_drop  out  1  one-cycle pulse on UP→non-UP transition.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE; mgt_tx_reset=4'hF, mgt_rx_reset=4'hF, cfg_status_reset=1; link_up=0, link_drop=0, retry_count=0; backoff exponent=0; all counters=0.
- Good status is defined as xaui_status[6:2]==5'b11111 && xaui_status[1:0]==2'b00.
- IDLE (0): all resets asserted. Go to RST_TX when enable=1.
- RST_TX (1):
  - mgt_tx_reset and mgt_rx_reset asserted for RST_CYCLES cycles, then go to RST_RX.
- RST_RX (2):
  - TX reset released, RX reset held.
  - Wait until mgt_rxlock==4'hF, then hold a further RST_CYCLES cycles, then release.
  - Go to WAIT_SYNC. The timeout counter runs from RST_RX entry.
- WAIT_SYNC (3): wait for xaui_status[5:2]==4'hF, then go to WAIT_ALIGN.
- WAIT_ALIGN (4): wait for xaui_status[6], then go to QUALIFY.
- Timeout: expiry in RST_RX, WAIT_SYNC or WAIT_ALIGN (a single counter, not restarted between these states) → BACKOFF, retry_count+1.
- QUALIFY (5):
  - cfg_status_reset pulses for 1 cycle on entry, clearing latched faults.
  - Count consecutive good-status cycles. Any bad cycle restarts the count; a bad cycle does not cause failure.
  - Count reaching QUAL_CYCLES → UP. Timeout also applies here → BACKOFF.
- UP (6):
  - link_up=1; retry_count=0; backoff exponent=0.
  - Any cycle of bad status → link_drop=1 for that cycle; link_up=0 on the next edge; go to RST_TX.
- BACKOFF (7):
  - All resets asserted. Wait 2^(TIMEOUT_BITS−8+exp) cycles, then go to RST_TX.
  - Exponent increments on exit, saturating at BACKOFF_MAX.
- cfg_status_reset=1 in IDLE, RST_TX and BACKOFF; 0 elsewhere except the QUALIFY entry pulse.
- Priority (highest first): enable=0 → IDLE from any state on the next edge; force_retrain → RST_TX from any state except IDLE; then normal transitions.
- force_retrain resets neither retry_count nor the backoff exponent.
- force_retrain while in RST_TX restarts the RST_CYCLES count.
- link_drop also pulses when leaving UP via enable=0 or force_retrain.
- All outputs are registered. State decisions use xaui_status sampled on the same edge (1-cycle response latency).

Optional Feature:
- Macro: XAUI_LINK_CTRL_STATS_EN.
- When defined:
  - Adds outputs drop_count[15:0] (UP exits) and timeout_count[15:0] (timeouts), both saturating.
  - Adds input stats_clear; a single-cycle pulse zeros both counters.
  - stats_clear takes precedence over a simultaneous increment.
- When not defined: these ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Shared package xaui_link_pkg:
  - 3-bit state encoding constants IDLE..BACKOFF (0..7).
  - xaui_status bit-index constants (TX_FAULT=0, RX_FAULT=1, SYNC_LO=2, ALIGN=6, RX_LINK=7).
- Sub-module sat_counter (width and saturate parameters, clear/inc) for retry_count and the stats counters.
- The FSM, timeout counter and backoff counter stay inline.

Test Plan (TIMEOUT_BITS=10, QUAL_CYCLES=8, RST_CYCLES=4 for all scenarios):
- Nominal bring-up: enable=1, rxlock=F after 10 cycles, status=8'h7C held → tx_reset drops after 4 cycles, rx_reset drops 4 cycles after lock, link_up=1 after 8 qualify cycles, retry_count=0.
- Sync never achieved: status=8'h00 → BACKOFF after 1023 cycles; retry_count=1; waits are 4, 8, 16, 32, 64, 64 cycles on successive retries (exponent saturates at 4).
- Link drop in UP: clear status[6] for 1 cycle → link_drop pulses once, link_up=0, FSM re-enters RST_TX with all resets=F.
- Qualify glitch: a bad status cycle at qualify count 5 → count restarts; link_up asserts 8 good cycles later, not 3.
- force_retrain and enable=0 in the same cycle while UP → IDLE (enable wins); link_drop=1; resets=F.
- Async reset mid-WAIT_ALIGN: reset_n low → all outputs at reset values immediately without a clock edge; with XAUI_LINK_CTRL_STATS_EN, timeout_count increments on each timeout and zeros on stats_clear.
